// File: rtl/mem_latency_unit.sv
// mem_latency_unit
//   Unified instruction/data word memory for the multicycle core. A request
//   is accepted in IDLE, waits out a fixed read or write latency in BUSY,
//   performs the access and then raises a one-cycle ready pulse in DONE.
//   Byte-enable writes serve sb/sh/sw; indices beyond the array are flagged
//   with addr_err and never touch memory.
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   asynchronous, active-low reset
//   req         in   access request, sampled only in IDLE
//   write       in   1 = write, 0 = read, sampled with req
//   address     in   byte address, bits [1:0] ignored
//   write_data  in   lane-aligned store data
//   byte_en     in   write lane enables, bit i -> bits [8i+7:8i]
//   ready       out  one-cycle completion pulse
//   read_data   out  read result, held until the next read completes
//   busy        out  high whenever state is not IDLE
//   addr_err    out  out-of-range flag, held until the next access completes
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req; inputs latched on acceptance
// BUSY  | latency counter running; access performed when it hits 0
// DONE  | ready pulse; req ignored; returns to IDLE on the next edge

module mem_latency_unit #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        addr_err
);

  localparam int AW      = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [CW-1:0] cnt;
  logic [29:0]   l_idx;
  logic          l_write;
  logic [31:0]   l_wdata;
  logic [3:0]    l_be;

  logic          accept;
  logic          fire;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [1:0]    unused_addr_bits;

  assign unused_addr_bits = address[1:0];

  // DEPTH_WORDS is a power of two, so any set bit above the word index
  // field means the access lies beyond the array.
  assign in_range = ((l_idx >> AW) == 30'd0);
  assign word_idx = l_idx[AW-1:0];

  assign ready = (state == DONE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          fire    = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      l_idx     <= '0;
      l_write   <= 1'b0;
      l_wdata   <= '0;
      l_be      <= '0;
      read_data <= '0;
      addr_err  <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        l_idx   <= address[31:2];
        l_write <= write;
        l_wdata <= write_data;
        l_be    <= byte_en;
        cnt     <= write ? WR_LOAD : RD_LOAD;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if (fire) begin
        addr_err <= !in_range;
        if (l_write) begin
          if (in_range) begin
            for (int i = 0; i < 4; i++) begin
              if (l_be[i]) begin
                mem[word_idx][8*i +: 8] <= l_wdata[8*i +: 8];
              end
            end
          end
        end else begin
          read_data <= in_range ? mem[word_idx] : 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_latency_unit.sv
// tb_mem_latency_unit
//   Drives randomized and directed accesses into mem_latency_unit and
//   compares every completion against a word-array reference model that
//   knows only the access rules (latency, lanes, range, hold behaviour).
//   A second instance with WRITE_LATENCY=3 covers reset during a write.

module tb_mem_latency_unit;

  localparam int DEPTH = 1024;
  localparam int RL    = 2;
  localparam int WL    = 1;
  localparam int RL2   = 2;
  localparam int WL2   = 3;
  localparam int DEPTH2 = 16;

  logic        clock;
  logic        reset;
  logic        req, write;
  logic [31:0] address, write_data;
  logic [3:0]  byte_en;
  logic        ready, busy, addr_err;
  logic [31:0] read_data;

  logic        reset2;
  logic        req2, write2;
  logic [31:0] address2, wdata2;
  logic [3:0]  be2;
  logic        ready2, busy2, err2;
  logic [31:0] rdata2;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata = 32'd0;
  logic        ref_err   = 1'b0;

  mem_latency_unit #(
    .DEPTH_WORDS(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .write(write),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .ready(ready), .read_data(read_data), .busy(busy), .addr_err(addr_err)
  );

  mem_latency_unit #(
    .DEPTH_WORDS(DEPTH2), .READ_LATENCY(RL2), .WRITE_LATENCY(WL2)
  ) dut2 (
    .clock(clock), .reset(reset2), .req(req2), .write(write2),
    .address(address2), .write_data(wdata2), .byte_en(be2),
    .ready(ready2), .read_data(rdata2), .busy(busy2), .addr_err(err2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'd0;
  endfunction

  // One access on dut: checks latency, busy duration, results, and that
  // ready does not repeat. Inputs are scrambled right after acceptance.
  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    int          lat, busy_cnt, k;
    logic [29:0] idx;
    logic        oor;
    logic [31:0] w;
    idx = addr[31:2];
    oor = (idx >= 30'(DEPTH));
    k   = int'(idx);

    @(negedge clock);
    req = 1'b1; write = wr; address = addr; write_data = wd; byte_en = be;
    @(posedge clock); #1;
    req = 1'b0; write = 1'($urandom); address = $urandom;
    write_data = $urandom; byte_en = 4'($urandom);

    lat = 0; busy_cnt = 0;
    while (!ready && lat < 64) begin
      if (busy) busy_cnt++;
      @(posedge clock); #1;
      lat++;
    end
    if (busy) busy_cnt++;

    ref_err = oor;
    if (wr) begin
      if (!oor) begin
        w = ref_word(k);
        for (int i = 0; i < 4; i++)
          if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        ref_mem[k] = w;
      end
    end else begin
      ref_rdata = oor ? 32'd0 : ref_word(k);
    end

    check({tag, "_latency"}, 32'(lat), wr ? 32'(WL) : 32'(RL));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), wr ? 32'(WL + 1) : 32'(RL + 1));
    check({tag, "_read_data"}, read_data, ref_rdata);
    check({tag, "_addr_err"}, 32'(addr_err), 32'(ref_err));
    @(posedge clock); #1;
    check({tag, "_ready_once"}, 32'(ready), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  // One access on dut2; returns latency and the read data it completed with.
  task automatic access2(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
    @(negedge clock);
    req2 = 1'b1; write2 = wr; address2 = addr; wdata2 = wd; be2 = 4'hF;
    @(posedge clock); #1;
    req2 = 1'b0;
    lat = 0;
    while (!ready2 && lat < 64) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = rdata2;
    @(posedge clock); #1;
  endtask

  initial begin
    int          t1, t2, cyc, lat;
    logic [31:0] rd, a, d;
    logic [29:0] idx;
    logic        seen;

    reset = 1'b0; reset2 = 1'b0;
    req = 1'b0; write = 1'b0; address = '0; write_data = '0; byte_en = '0;
    req2 = 1'b0; write2 = 1'b0; address2 = '0; wdata2 = '0; be2 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    @(negedge clock);
    reset = 1'b1; reset2 = 1'b1;

    // directed sequence from the test plan
    access("rd_0x10", 1'b0, 32'h0000_0010, 32'd0, 4'h0);
    access("wr_0x40", 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
    access("rd_0x40", 1'b0, 32'h0000_0040, 32'd0, 4'h0);
    check("full_word_readback", read_data, 32'hDEAD_BEEF);
    access("wr_lane2", 1'b1, 32'h0000_0040, 32'h00AB_0000, 4'b0100);
    access("wr_lane0", 1'b1, 32'h0000_0040, 32'h0000_00CD, 4'b0001);
    access("wr_be0", 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000);
    access("rd_lanes", 1'b0, 32'h0000_0040, 32'd0, 4'h0);
    check("lane_readback", read_data, 32'hDEAB_BECD);
    access("rd_oor", 1'b0, 32'h0000_1000, 32'd0, 4'h0);
    check("oor_read_zero", read_data, 32'd0);
    check("oor_read_err", 32'(addr_err), 32'd1);
    access("wr_oor", 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
    check("oor_write_err", 32'(addr_err), 32'd1);
    access("rd_word0", 1'b0, 32'h0000_0000, 32'd0, 4'h0);
    check("word0_untouched", read_data, 32'd0);
    access("rd_last", 1'b0, 32'h0000_0FFF, 32'd0, 4'h0);

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        8:       idx = 30'(DEPTH - 1);
        9:       idx = 30'(DEPTH + $urandom_range(0, 4000));
        default: idx = 30'($urandom_range(0, 7));
      endcase
      a = {idx, 2'($urandom)};
      d = $urandom;
      access($sformatf("rand%0d", n), 1'($urandom), a, d, 4'($urandom));
    end

    // req held high across back-to-back reads of 0x40
    @(negedge clock);
    req = 1'b1; write = 1'b0; address = 32'h0000_0040;
    t1 = -1; t2 = -1; cyc = 0;
    while (t2 < 0 && cyc < 40) begin
      @(posedge clock); #1;
      if (ready) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
      cyc++;
    end
    @(negedge clock);
    req = 1'b0;
    ref_rdata = ref_word(16);
    ref_err   = 1'b0;
    check("held_first_latency", 32'(t1), 32'(RL));
    check("held_gap_cycles", 32'(t2 - t1 - 1), 32'(RL + 1));
    check("held_read_data", read_data, ref_rdata);
    repeat (2) @(posedge clock);
    #1;
    check("held_idle_after", 32'(busy), 32'd0);

    // dut2: confirm the 3-edge write path, then reset during a write
    access2(1'b1, 32'h0000_000C, 32'hCAFE_F00D, lat, rd);
    check("wl3_write_latency", 32'(lat), 32'(WL2));
    access2(1'b0, 32'h0000_000C, 32'd0, lat, rd);
    check("wl3_readback", rd, 32'hCAFE_F00D);

    @(negedge clock);
    req2 = 1'b1; write2 = 1'b1; address2 = 32'h0000_0008;
    wdata2 = 32'h1234_5678; be2 = 4'hF;
    @(posedge clock); #1;
    req2 = 1'b0;
    check("midrst_busy_before", 32'(busy2), 32'd1);
    @(posedge clock); #2;
    reset2 = 1'b0;
    #1;
    check("midrst_busy_now", 32'(busy2), 32'd0);
    check("midrst_ready_now", 32'(ready2), 32'd0);
    @(negedge clock);
    reset2 = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (ready2) seen = 1'b1;
    end
    check("midrst_no_ready", 32'(seen), 32'd0);
    access2(1'b0, 32'h0000_0008, 32'd0, lat, rd);
    check("midrst_read_latency", 32'(lat), 32'(RL2));
    check("midrst_read_zero", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_latency_unit.md
Name: mem_latency_unit

Overview:
- Unified instruction/data word memory for the multicycle core, with a request/ready handshake and parameterised access latency.
- Sits directly downstream of the core's address mux and B register, and upstream of the instruction register and memory data register.
- The core controller holds its fetch or memory state until the ready pulse arrives.
- Supports byte-enable writes for sb/sh/sw and flags out-of-range addresses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- READ_LATENCY, 2, clock edges from request acceptance to read completion; must be at least 1.
- WRITE_LATENCY, 1, clock edges from request acceptance to write commit; must be at least 1.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; sampled with req.
- address  in  32  byte address; bits [1:0] are ignored for word selection.
- write_data  in  32  store data, already lane-aligned by the core.
- byte_en  in  4  write lane enables; bit i enables bits [8i+7:8i].
- ready  out  1  one-cycle completion pulse.
- read_data  out  32  read result, valid when ready is high.
- busy  out  1  high whenever state is not IDLE.
- addr_err  out  1  out-of-range flag, valid with ready.

Behaviour:
- Reset (reset low, asynchronous): state goes to IDLE; ready, busy and addr_err go to 0; read_data goes to 0; all memory words are zeroed.
- Reset mid-operation: the pending request is abandoned and no write commits.
- States are IDLE, BUSY and DONE.
- IDLE behaviour:
  - At a rising edge with req=1, latch address, write, write_data and byte_en.
  - Load the counter with (write ? WRITE_LATENCY : READ_LATENCY) - 1.
  - Go to BUSY.
  - With req=0, stay in IDLE.
- BUSY behaviour:
  - At each edge with counter > 0, decrement the counter.
  - At the edge with counter == 0, perform the access using the latched values, then go to DONE.
- Read access: read_data is loaded with mem[index]; addr_err is set to 0.
- Write access: for each i with byte_en[i]=1, lane i of mem[index] takes write_data lane i; the other lanes keep their value. read_data is unchanged.
- Index and range check:
  - index = latched address[31:2].
  - If index >= DEPTH_WORDS, the access is out of range:
    - No memory change.
    - A read loads read_data with 0.
    - addr_err is set to 1.
    - The access otherwise completes normally.
- DONE behaviour: ready=1 for exactly this one cycle; req is ignored; the next edge goes to IDLE.
- Timing:
  - If req is accepted at edge k, ready is high in the cycle following edge k+LAT.
  - A new request can be accepted no earlier than edge k+LAT+2.
- Hold rules:
  - read_data holds its value until the next read completes.
  - addr_err holds until the next access completes.
- Writes are not readable until committed; a read accepted after a write's ready pulse returns the new data.
- byte_en=0000 on a write leaves memory unchanged but still produces the ready pulse.
- Inputs that change after acceptance have no effect on the access in flight.
- busy = (state != IDLE), driven from registered state.

Test Plan:
- Reset then read: assert reset low, release, issue a read at 0x00000010 with READ_LATENCY=2. Required: ready pulses exactly once, 2 edges after acceptance, with read_data=0x00000000, addr_err=0, and busy high for 3 cycles.
- Full-word write then readback: write 0xDEADBEEF to 0x00000040 with byte_en=1111, then read 0x00000040. Required: the write's ready comes 1 edge after acceptance; the read returns 0xDEADBEEF.
- Byte-lane writes: from 0xDEADBEEF at 0x40, write 0x00AB0000 with byte_en=0100, then write 0x000000CD with byte_en=0001, then read. Required: read_data=0xDEABBECD.
- Out of range: with DEPTH_WORDS=1024, read 0x00001000, and separately write 0xFFFFFFFF to 0x00001000. Required: both complete with ready and addr_err=1, the read returns read_data=0, and word 0 still reads 0 afterwards.
- Request ignored while busy: hold req=1 continuously across a read. Required: the second access is accepted only at the edge after DONE, with ready pulses separated by exactly READ_LATENCY+1 cycles.
- Reset mid-write: with WRITE_LATENCY=3, accept a write of 0x12345678 to 0x8, then pulse reset low one cycle later. Required: ready never pulses for that write, busy=0 immediately, and a subsequent read of 0x8 returns 0x00000000.
